uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among several byte-stream requesters, such as the cipher output path, the command/status responder and the error reporter. It grants one requester at a time using round-robin priority and holds that grant for a whole frame. A frame is a run of bytes ending with `last`, so multi-byte responses are never interleaved. It sits between the requesters and the UART TX, drives the UART's `tx_byte`/`tx_start`, and watches `tx_busy`.

---
 rtl/enigma_pkg.sv | 26 ++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default timeouts and a small index helper.
package enigma_pkg;

  localparam int unsigned CLK_FREQ         = 12_000_000;
  // tx_busy normally rises within a couple of cycles of tx_start.
  localparam int unsigned ACK_TIMEOUT_DEF  = 4;
  // 100 ms of idle time inside a frame before the grant is revoked.
  localparam int unsigned LOCK_TIMEOUT_DEF = CLK_FREQ / 10;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_WAIT_ACK,
    ARB_WAIT_DONE
  } arb_state_e;

  // Next index after idx, wrapping to zero at n.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return 2'd0;
    end
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// at or above the pointer, wrapping past the top index.
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    logic [SelW-1:0] j;
    j     = '0;
    idx_o = '0;
    any_o = |req_i;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      j = SelW'((int'(ptr_i) + off) % int'(N));
      if (req_i[j]) begin
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte-stream
// requesters. A grant is held for a whole frame (up to a byte flagged last),
// with a lock timeout for stalled requesters and an ack timeout on tx_busy.
module uart_tx_arbiter
  import enigma_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_byte_o,
  output logic                 tx_start_o,
  input  logic                 tx_busy_i,
  output logic [1:0]           grant_id_o,
  output logic                 frame_active_o,
  output logic                 lock_abort_o,
  output logic                 tx_fault_o
);

  localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned LockW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       grant_q;
  logic             frame_active_q;
  logic [7:0]       tx_byte_q;
  logic             tx_start_q;
  logic             last_q;
  logic             lock_abort_q;
  logic             tx_fault_q;
  logic [AckW-1:0]  ack_cnt_q;
  logic [LockW-1:0] lock_cnt_q;

  logic [1:0]       pick_idx;
  logic             pick_any;
  logic [7:0]       byte_arr [NUM_REQ];
  logic             gnt_valid;
  logic             gnt_last;
  logic [7:0]       gnt_byte;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (2)
  ) u_rr_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Select the granted requester's byte lane and flags.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      byte_arr[i] = req_byte_i[8*i +: 8];
    end
    gnt_valid = req_valid_i[grant_q];
    gnt_last  = req_last_i[grant_q];
    gnt_byte  = byte_arr[grant_q];
  end

  // Only the granted requester is ever readied, and only while in GRANT.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ARB_GRANT) begin
      req_ready_o[grant_q] = gnt_valid;
    end
  end

  // Arbiter FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ARB_IDLE;
      ptr_q          <= '0;
      grant_q        <= '0;
      frame_active_q <= 1'b0;
      tx_byte_q      <= '0;
      tx_start_q     <= 1'b0;
      last_q         <= 1'b0;
      lock_abort_q   <= 1'b0;
      tx_fault_q     <= 1'b0;
      ack_cnt_q      <= '0;
      lock_cnt_q     <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      lock_abort_q <= 1'b0;
      tx_fault_q   <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q        <= pick_idx;
            frame_active_q <= 1'b1;
            lock_cnt_q     <= '0;
            state_q        <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (gnt_valid) begin
            tx_byte_q  <= gnt_byte;
            last_q     <= gnt_last;
            tx_start_q <= 1'b1;
            lock_cnt_q <= '0;
            ack_cnt_q  <= '0;
            state_q    <= ARB_WAIT_ACK;
          end else if (lock_cnt_q >= LockW'(LOCK_TIMEOUT - 1)) begin
            // Stalled mid-frame: revoke the grant and move the pointer on.
            lock_abort_q   <= 1'b1;
            lock_cnt_q     <= '0;
            ptr_q          <= wrap_inc(grant_q, NUM_REQ);
            frame_active_q <= 1'b0;
            state_q        <= ARB_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        ARB_WAIT_ACK: begin
          if (tx_busy_i) begin
            state_q <= ARB_WAIT_DONE;
          end else if (ack_cnt_q >= AckW'(ACK_TIMEOUT - 1)) begin
            // UART never acknowledged; report and carry on with the frame.
            tx_fault_q <= 1'b1;
            state_q    <= ARB_WAIT_DONE;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        ARB_WAIT_DONE: begin
          if (!tx_busy_i) begin
            if (last_q) begin
              ptr_q          <= wrap_inc(grant_q, NUM_REQ);
              frame_active_q <= 1'b0;
              state_q        <= ARB_IDLE;
            end else begin
              state_q <= ARB_GRANT;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign tx_byte_o      = tx_byte_q;
  assign tx_start_o     = tx_start_q;
  assign grant_id_o     = grant_q;
  assign frame_active_o = frame_active_q;
  assign lock_abort_o   = lock_abort_q;
  assign tx_fault_o     = tx_fault_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a simple
// UART busy model and a scoreboard of expected {grant_id, byte} transfers.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid;
  logic [23:0] req_byte;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        frame_active;
  logic        lock_abort;
  logic        tx_fault;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int bcnt   = 0;
  logic uart_en = 1'b1;

  logic [8:0] srcq [3][$];
  logic [9:0] expq [$];
  int start_cnt  = 0;
  int last_start = 0;
  int abort_cnt  = 0;
  int fault_cnt  = 0;
  int viol       = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (3),
    .ACK_TIMEOUT  (4),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_byte_i     (req_byte),
    .req_last_i     (req_last),
    .req_ready_o    (req_ready),
    .tx_byte_o      (tx_byte),
    .tx_start_o     (tx_start),
    .tx_busy_i      (tx_busy),
    .grant_id_o     (grant_id),
    .frame_active_o (frame_active),
    .lock_abort_o   (lock_abort),
    .tx_fault_o     (tx_fault)
  );

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for 5 cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (uart_en && tx_start) bcnt <= 5;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int n = 0;
    while (tx_busy !== level && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_busy), 32'(level));
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() != 0 || expq.size() != 0 ||
            frame_active || tx_busy || req_valid != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(req_ready), 0);
    check({tag, "_txbyte"}, 32'(tx_byte), 0);
    check({tag, "_start"},  32'(tx_start), 0);
    check({tag, "_gid"},    32'(grant_id), 0);
    check({tag, "_active"}, 32'(frame_active), 0);
    check({tag, "_abort"},  32'(lock_abort), 0);
    check({tag, "_fault"},  32'(tx_fault), 0);
    check({tag, "_ptr"},    32'(dut.ptr_q), 0);
    check({tag, "_state"},  32'(dut.state_q), 0);
  endtask

  // Requester driver: pop on handshake, then present the queue head.
  initial begin
    logic [2:0] take;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      take = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (take[i]) void'(srcq[i].pop_front());
        if (srcq[i].size() != 0) begin
          req_valid[i]        = 1'b1;
          req_byte[i*8 +: 8]  = srcq[i][0][7:0];
          req_last[i]         = srcq[i][0][8];
        end else begin
          req_valid[i]        = 1'b0;
          req_byte[i*8 +: 8]  = 8'h00;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard, fault timing, pulse widths, ready legality.
  initial begin
    logic [9:0] e;
    logic       prev_abort;
    logic       prev_fault;
    prev_abort = 1'b0;
    prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_cnt++;
        last_start = cyc;
        check("start_while_busy", 32'(tx_busy), 0);
        if (expq.size() == 0) begin
          check("unexpected_byte", 32'(expq.size()), 1);
        end else begin
          e = expq.pop_front();
          check("sb_grant_id", 32'(grant_id), 32'(e[9:8]));
          check("sb_tx_byte", 32'(tx_byte), 32'(e[7:0]));
        end
      end
      if (tx_fault === 1'b1) begin
        fault_cnt++;
        check("fault_delay", 32'(cyc - last_start), 4);
      end
      if (lock_abort === 1'b1) abort_cnt++;
      if ((lock_abort === 1'b1 && prev_abort) || (tx_fault === 1'b1 && prev_fault)) viol++;
      prev_abort = (lock_abort === 1'b1);
      prev_fault = (tx_fault === 1'b1);
      if (!rst && (req_ready & ~(frame_active ? (3'b001 << grant_id) : 3'b000)) != 0) viol++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c0;
    int s0;
    int a0;
    int f0;
    int v0;

    // Reset values.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request: requester 1 sends "AB".
    s0 = start_cnt;
    srcq[1].push_back({1'b0, 8'h41});
    srcq[1].push_back({1'b1, 8'h42});
    expq.push_back({2'd1, 8'h41});
    expq.push_back({2'd1, 8'h42});
    n = 0;
    while (!req_valid[1] && n < 20) begin @(negedge clk); n++; end
    c0 = cyc;
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("arb_latency", 32'(cyc - c0), 2);
    n = 0;
    while (start_cnt < s0 + 2 && n < 100) begin @(negedge clk); n++; end
    check("single_starts", 32'(start_cnt - s0), 2);
    wait_busy(1'b1, "single_busy_rise");
    wait_busy(1'b0, "single_busy_fall");
    check("single_active_held", 32'(frame_active), 1);
    @(negedge clk);
    check("single_active_drop", 32'(frame_active), 0);
    check("single_gid", 32'(grant_id), 1);
    check("single_ptr", 32'(dut.ptr_q), 2);
    wait_quiet("single");

    // Lock timeout: requester 2 stalls mid-frame while 0 waits.
    a0 = abort_cnt;
    srcq[2].push_back({1'b0, 8'h55});
    srcq[0].push_back({1'b1, 8'h10});
    expq.push_back({2'd2, 8'h55});
    expq.push_back({2'd0, 8'h10});
    wait_busy(1'b1, "lock_busy_rise");
    wait_busy(1'b0, "lock_busy_fall");
    n = 0;
    while (lock_abort !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check("lock_abort_delay", 32'(n), 17);
    check("lock_frame_drop", 32'(frame_active), 0);
    check("lock_gid_hold", 32'(grant_id), 2);
    wait_quiet("lock");
    check("lock_abort_count", 32'(abort_cnt - a0), 1);

    // Round-robin from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_reset_ptr", 32'(dut.ptr_q), 0);
    for (int i = 0; i < 3; i++) begin
      srcq[i].push_back({1'b1, 8'h30 + 8'(i)});
      expq.push_back({2'(i), 8'h30 + 8'(i)});
    end
    wait_quiet("rr_all");
    check("rr_ptr_wrap", 32'(dut.ptr_q), 0);
    srcq[0].push_back({1'b1, 8'h40});
    srcq[2].push_back({1'b1, 8'h42});
    expq.push_back({2'd0, 8'h40});
    expq.push_back({2'd2, 8'h42});
    wait_quiet("rr_02");

    // Frame lock: requester 0's 3-byte frame is not interleaved with 1.
    v0 = viol;
    srcq[0].push_back({1'b0, 8'h61});
    srcq[0].push_back({1'b0, 8'h62});
    srcq[0].push_back({1'b1, 8'h63});
    srcq[1].push_back({1'b1, 8'h71});
    expq.push_back({2'd0, 8'h61});
    expq.push_back({2'd0, 8'h62});
    expq.push_back({2'd0, 8'h63});
    expq.push_back({2'd1, 8'h71});
    wait_quiet("frame_lock");
    check("frame_lock_ready_viol", 32'(viol - v0), 0);
    check("frame_lock_ptr", 32'(dut.ptr_q), 2);

    // ACK fault: UART never raises busy.
    uart_en = 1'b0;
    f0 = fault_cnt;
    srcq[1].push_back({1'b0, 8'h78});
    srcq[1].push_back({1'b1, 8'h79});
    expq.push_back({2'd1, 8'h78});
    expq.push_back({2'd1, 8'h79});
    wait_quiet("ack_fault");
    check("ack_fault_count", 32'(fault_cnt - f0), 2);
    uart_en = 1'b1;

    // Reset during WAIT_DONE.
    srcq[1].push_back({1'b1, 8'h5A});
    expq.push_back({2'd1, 8'h5A});
    wait_busy(1'b1, "midrst_busy_rise");
    @(negedge clk);
    check("midrst_state_before", 32'(dut.state_q), 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_busy(1'b0, "midrst_busy_fall");
    repeat (3) @(negedge clk);
    check("midrst_no_extra", 32'(expq.size()), 0);
    check("pulse_and_ready_viol", 32'(viol), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
